// File: rtl/im_loader_pkg.sv
// Shared encodings and derived sizes for the instruction-memory loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package im_loader_pkg;

    localparam int IMW_DEF = 4;
    localparam int IW_DEF  = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_START = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    function automatic int calc_bpw(input int iw);
        return iw / 8;
    endfunction

    // A byte-index counter needs at least one bit even for single-byte words.
    function automatic int calc_biw(input int bpw);
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

endpackage

// File: rtl/im_loader_byte_packer.sv
// Little-endian byte-to-word assembler; byte k lands in bits [8k+7:8k].
// Latency: word_nxt is combinational on the completing byte; register updates on shift.
// Backpressure: none; the caller gates shift with the stream handshake.
module im_loader_byte_packer
    import im_loader_pkg::*;
#(
    parameter int IW  = IW_DEF,
    parameter int BIW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           shift,
    input  logic [BIW-1:0] byte_idx,
    input  logic [7:0]     byte_dat,
    output logic [IW-1:0]  word_nxt,
    output logic           word_full
);

    localparam int BPW = calc_bpw(IW);

    logic [IW-1:0] word_q;

    // New bytes enter at the top and shift down, so after BPW bytes byte 0 sits at the bottom.
    generate
        if (BPW == 1) begin : g_single
            assign word_nxt = byte_dat;
        end else begin : g_multi
            assign word_nxt = {byte_dat, word_q[IW-1:8]};
        end
    endgenerate

    assign word_full = shift && (byte_idx == BIW'(BPW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else if (shift) begin
            word_q <= word_nxt;
        end
    end

endmodule

// File: rtl/im_loader.sv
// Loads a header-prefixed byte stream into IM words from address 0, then pulses start.
// Latency: im_we one cycle after the last byte of a word; start one cycle after the final im_we.
// Backpressure: byte_ready high only in HDR/DATA; byte_valid low stalls without timeout.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int IMW = IMW_DEF,
    parameter int IW  = IW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_req,
    input  logic [7:0]     byte_in,
    input  logic           byte_valid,
    output logic           byte_ready,
    output logic           im_we,
    output logic [IMW-1:0] im_waddr,
    output logic [IW-1:0]  im_wdata,
    output logic           start,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int BPW = calc_bpw(IW);
    localparam int BIW = calc_biw(BPW);
    localparam logic [31:0] HDR_MAX = 32'((64'd1 << IMW) - 64'd1);

    state_t         state_q, state_n;
    logic [IMW-1:0] word_idx_q;
    logic [IMW-1:0] last_idx_q;
    logic [BIW-1:0] byte_idx_q;
    logic           xfer;
    logic           shift;
    logic           hdr_ok;
    logic [IMW-1:0] hdr_idx;
    logic           word_full;
    logic [IW-1:0]  word_nxt;

    assign xfer    = byte_valid && byte_ready;
    assign shift   = xfer && (state_q == ST_DATA);
    assign hdr_ok  = ({24'd0, byte_in} <= HDR_MAX);
    assign hdr_idx = IMW'(byte_in);

    im_loader_byte_packer #(
        .IW  (IW),
        .BIW (BIW)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift     (shift),
        .byte_idx  (byte_idx_q),
        .byte_dat  (byte_in),
        .word_nxt  (word_nxt),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (load_req) state_n = ST_HDR;
            end
            ST_HDR: begin
                if (xfer) state_n = hdr_ok ? ST_DATA : ST_ERR;
            end
            ST_DATA: begin
                if (word_full) state_n = ST_WRITE;
            end
            ST_WRITE: begin
                state_n = (word_idx_q == last_idx_q) ? ST_START : ST_DATA;
            end
            ST_START: state_n = ST_DONE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            im_we      <= 1'b0;
            start      <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            im_waddr   <= '0;
            im_wdata   <= '0;
            word_idx_q <= '0;
            last_idx_q <= '0;
            byte_idx_q <= '0;
        end else begin
            byte_ready <= (state_n == ST_HDR) || (state_n == ST_DATA);
            busy       <= (state_n == ST_HDR) || (state_n == ST_DATA) ||
                          (state_n == ST_WRITE) || (state_n == ST_START);
            im_we      <= (state_n == ST_WRITE);
            start      <= (state_n == ST_START);
            done       <= (state_n == ST_DONE);
            err        <= (state_n == ST_ERR);

            if ((state_q == ST_HDR) && xfer && hdr_ok) begin
                last_idx_q <= hdr_idx;
                word_idx_q <= '0;
                byte_idx_q <= '0;
            end

            if (shift) begin
                byte_idx_q <= word_full ? '0 : byte_idx_q + BIW'(1);
            end

            if ((state_q == ST_DATA) && (state_n == ST_WRITE)) begin
                im_waddr <= word_idx_q;
                im_wdata <= word_nxt;
            end

            // Increment only when another word follows, so a full-depth load never wraps.
            if ((state_q == ST_WRITE) && (state_n == ST_DATA)) begin
                word_idx_q <= word_idx_q + IMW'(1);
            end
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader with IMW=4, IW=32.
// Tracks IM writes and start pulses at the falling edge and compares against hand-computed values.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_req;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        im_we;
    logic [3:0]  im_waddr;
    logic [31:0] im_wdata;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int load_cyc;
    int n_start;
    int start_cyc;
    int rdy_in_write;
    int          wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    logic [31:0] mem [16];

    im_loader #(.IMW(4), .IW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_req   (load_req),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_waddr   (im_waddr),
        .im_wdata   (im_wdata),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (im_we) mem[im_waddr] <= im_wdata;
    end

    always @(negedge clk) begin
        if (im_we) begin
            wa.push_back(int'(im_waddr));
            wd.push_back(im_wdata);
            wc.push_back(cyc);
            if (byte_ready) rdy_in_write++;
        end
        if (start) begin
            n_start++;
            start_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
        n_start = 0;
        start_cyc = -1;
        rdy_in_write = 0;
    endtask

    task automatic pulse_load();
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        load_cyc = cyc;
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall);
        int t = 0;
        byte_valid = 1'b0;
        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        byte_in = b;
        byte_valid = 1'b1;
        while (!byte_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("byte_ready_timeout", 64'(t), 64'd0);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_stall);
        logic [31:0] v;
        v = w;
        for (int k = 0; k < 4; k++) begin
            send_byte(v[8*k +: 8], (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0);
        end
    endtask

    task automatic wait_end();
        int t = 0;
        while (!(done || err) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 500) chk("end_timeout", 64'(t), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        load_req = 1'b0;
        byte_in = 8'h00;
        byte_valid = 1'b0;
        clear_log();
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_flags", {byte_ready, im_we, start, busy, done, err}, 6'b0);
        chk("rst_waddr", im_waddr, 4'h0);
        chk("rst_wdata", im_wdata, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", byte_ready, 1'b0);

        // Basic two-word load and cycle timing
        clear_log();
        pulse_load();
        chk("basic_busy", busy, 1'b1);
        send_byte(8'h01, 0);
        send_word(32'h00500013, 0);
        send_word(32'h002101B3, 0);
        wait_end();
        chk("basic_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("basic_a0", wa[0], 0);
            chk("basic_d0", wd[0], 32'h00500013);
            chk("basic_a1", wa[1], 1);
            chk("basic_d1", wd[1], 32'h002101B3);
            chk("basic_we0_lat", wc[0] - load_cyc, 5);
            chk("basic_we1_lat", wc[1] - load_cyc, 10);
            chk("basic_start_lat", start_cyc - wc[1], 1);
        end
        chk("basic_start_lat_total", start_cyc - load_cyc, 11);
        chk("basic_nstart", n_start, 1);
        chk("basic_flags", {done, busy, err, byte_ready}, 4'b1000);

        // Header out of range
        clear_log();
        pulse_load();
        chk("err_done_clr", done, 1'b0);
        send_byte(8'h10, 0);
        wait_end();
        byte_in = 8'hAA;
        byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        chk("err_flags", {err, done, busy, byte_ready}, 4'b1000);
        chk("err_nwr", wa.size(), 0);
        chk("err_nstart", n_start, 0);
        pulse_load();
        chk("err_clr", err, 1'b0);
        send_byte(8'h00, 0);
        send_word(32'hDEADBEEF, 0);
        wait_end();
        chk("rec_nwr", wa.size(), 1);
        if (wa.size() == 1) begin
            chk("rec_a0", wa[0], 0);
            chk("rec_d0", wd[0], 32'hDEADBEEF);
        end
        chk("rec_flags", {done, err}, 2'b10);
        chk("rec_nstart", n_start, 1);

        // Full depth
        clear_log();
        pulse_load();
        send_byte(8'h0F, 0);
        for (int i = 0; i < 16; i++) send_word(32'h01010101 * i, 0);
        wait_end();
        chk("full_nwr", wa.size(), 16);
        for (int i = 0; i < 16 && i < wa.size(); i++) begin
            chk($sformatf("full_a%0d", i), wa[i], i);
            chk($sformatf("full_d%0d", i), wd[i], 32'h01010101 * i);
        end
        chk("full_mem15", mem[15], 32'h0F0F0F0F);
        chk("full_nstart", n_start, 1);
        chk("full_done", done, 1'b1);

        // Random stalls plus a load_req while busy
        clear_log();
        pulse_load();
        send_byte(8'h01, 2);
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        send_word(32'h00500013, 3);
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        send_word(32'h002101B3, 3);
        wait_end();
        chk("stall_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("stall_a0", wa[0], 0);
            chk("stall_d0", wd[0], 32'h00500013);
            chk("stall_a1", wa[1], 1);
            chk("stall_d1", wd[1], 32'h002101B3);
        end
        chk("stall_ready_in_write", rdy_in_write, 0);
        chk("stall_nstart", n_start, 1);
        chk("stall_flags", {done, err, busy}, 3'b100);

        // Reset in the middle of word 1
        clear_log();
        pulse_load();
        send_byte(8'h01, 0);
        send_word(32'hCAFEF00D, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flags", {byte_ready, im_we, start, busy, done, err}, 6'b0);
        chk("mid_rst_waddr", im_waddr, 4'h0);
        chk("mid_rst_wdata", im_wdata, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_rst_nwr", wa.size(), 1);
        chk("mid_rst_nstart", n_start, 0);
        chk("mid_rst_mem0", mem[0], 32'hCAFEF00D);
        chk("mid_rst_mem1", mem[1], 32'h002101B3);
        chk("mid_rst_idle", {busy, done, err}, 3'b000);
        clear_log();
        pulse_load();
        send_byte(8'h00, 0);
        send_word(32'h11223344, 0);
        wait_end();
        chk("post_rst_nwr", wa.size(), 1);
        if (wa.size() == 1) chk("post_rst_d0", wd[0], 32'h11223344);
        chk("post_rst_nstart", n_start, 1);

        // Back-to-back load from DONE
        clear_log();
        pulse_load();
        chk("b2b_done_clr", {done, busy}, 2'b01);
        send_byte(8'h01, 0);
        send_word(32'hA5A5_0001, 0);
        send_word(32'h5A5A_0002, 0);
        wait_end();
        chk("b2b_nwr", wa.size(), 2);
        chk("b2b_mem0", mem[0], 32'hA5A50001);
        chk("b2b_mem1", mem[1], 32'h5A5A0002);
        chk("b2b_nstart", n_start, 1);
        chk("b2b_done", done, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Program loader that writes the instruction memory, the counterpart of the core's fetch path, which only reads it.
- Receives a byte stream over a valid/ready handshake and assembles it into IW-bit instruction words.
- Writes the words to sequential IM addresses starting at 0, then pulses the core start input once.
- Sits between a host byte source (UART/JTAG bridge) and the IM write port / core start.

Parameters:
- IMW, 4, IM address width; IM depth is 2^IMW words.
- IW, 32, instruction width in bits; must be a multiple of 8.
- BPW, IW/8, bytes per word (derived localparam, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_req  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts byte_in this cycle.
- im_we  output  1  IM write enable, one cycle per word.
- im_waddr  output  IMW  IM write address.
- im_wdata  output  IW  IM write data.
- start  output  1  one-cycle pulse to the core after the last word is written.
- busy  output  1  high in HDR, DATA, WRITE and START.
- done  output  1  sticky; load completed.
- err  output  1  sticky; header out of range.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; word index and byte index 0; assembly register 0.
  - A reset mid-load abandons the load. No further im_we is issued. IM contents already written are left as-is.
- All outputs are registered. A byte transfer occurs on a rising edge where byte_valid && byte_ready.
- States:
  - IDLE: byte_ready=0. On load_req, go to HDR and clear done and err.
  - HDR: byte_ready=1. The first accepted byte is the header H = word count minus 1.
    - If H <= 2^IMW-1: latch last_idx=H[IMW-1:0], word index=0, byte index=0, go to DATA.
    - Otherwise: go to ERR. No IM write occurs.
  - DATA: byte_ready=1. Each accepted byte is placed little-endian: byte k of the word goes to bits [8k+7:8k].
    - On the transfer with byte index = BPW-1, go to WRITE.
  - WRITE, exactly one cycle: byte_ready=0, im_we=1, im_waddr=word index, im_wdata=assembled word. The IM write lands on the same edge that leaves WRITE.
    - If word index == last_idx, go to START.
    - Otherwise increment the word index, reset the byte index, and return to DATA.
  - START, one cycle: start=1, then go to DONE.
  - DONE: done=1, byte_ready=0. On load_req, go to HDR.
  - ERR: err=1, byte_ready=0. On load_req, go to HDR.
- Latency:
  - im_we is high in the cycle after the edge that accepts the final byte of a word.
  - start is high in the cycle after im_we for the last word.
  - Minimum load time is 1 + N*(BPW+1) + 1 cycles after load_req, for N words with no stalls.
- byte_valid low stalls HDR/DATA indefinitely. No timeout.
- im_waddr and im_wdata hold their last values when im_we=0. im_we is never asserted outside WRITE.
- load_req while busy is ignored. Bytes presented while byte_ready=0 are not consumed.
- H = 2^IMW-1 (full IM) is legal; the word index must not wrap before WRITE of the last word.
- start is never asserted without a complete load. It is never asserted after ERR or after a reset mid-load.

Decomposition:
- Shared package/include: state encoding constants (IDLE, HDR, DATA, WRITE, START, DONE, ERR) and the BPW derivation.
- IMW and IW defaults match the core's existing parameter set.
- Sub-module byte_packer: shifts BPW bytes into an IW-bit word and flags word_full. The FSM and counters stay in im_loader.

Test Plan:
- Basic load, IMW=4: load_req; header 0x01; bytes 0x13,0x00,0x50,0x00, 0xB3,0x01,0x21,0x00 → im_we at addr 0 with 0x00500013, then addr 1 with 0x002101B3; start pulses once, one cycle after the second im_we; done=1; busy=0.
- Range error: header 0x10 → err=1; no im_we; no start; byte_ready=0. A following load_req with header 0x00 and one word loads addr 0 and clears err.
- Full depth: header 0x0F with 16 words of data = index*0x01010101 → 16 writes to addrs 0..15 in order; addr 15 gets 0x0F0F0F0F; one start pulse.
- Stalls: byte_valid toggled randomly during DATA → identical writes and data to the unstalled run; byte_ready=0 during WRITE; load_req asserted while busy has no effect.
- Reset mid-load: assert rst_n=0 after 2 bytes of word 1 → all outputs 0 immediately; no further im_we or start. After release, a load_req restarts cleanly from HDR.
- Back-to-back: a second load_req in DONE with a new program → done clears, the new words overwrite from addr 0, and start pulses again.
